// File: rtl/vbeat_seq.sv
// Vector beat sequencer: turns one vl/vsew op into a stream of VRF word indices and byte
// enables, masking tail bytes on the final beat.
module vbeat_seq #(
  parameter int unsigned VLEN          = 16384,
  parameter int unsigned VLMAX         = VLEN / 8,
  parameter int unsigned VL_BITS       = $clog2(VLMAX) + 1,
  parameter int unsigned DATA_WIDTH    = 64,
  parameter bit          ENABLE_64_BIT = 1'b1,
  parameter int unsigned IDX_BITS      = $clog2(VLEN / (DATA_WIDTH / 8))
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [VL_BITS-1:0]        in_vl,
  input  logic [2:0]                in_vsew,
  input  logic                      in_vill,
  output logic                      beat_valid,
  input  logic                      beat_ready,
  output logic [IDX_BITS-1:0]       beat_idx,
  output logic [DATA_WIDTH/8-1:0]   beat_be,
  output logic                      beat_last,
  output logic                      done,
  output logic                      err
);

  localparam int unsigned BPB  = DATA_WIDTH / 8;
  localparam int unsigned TB_W = $clog2(VLEN) + 1;
  localparam logic [TB_W-1:0] BpbW    = TB_W'(BPB);
  localparam logic [2:0]      MaxVsew = ENABLE_64_BIT ? 3'd3 : 3'd2;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e              state_q, state_d;
  logic [TB_W-1:0]     rem_q, rem_d;
  logic [IDX_BITS-1:0] idx_q, idx_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic [TB_W-1:0]     tb_bytes;
  logic                illegal;
  logic [BPB-1:0]      tail_be;

  assign tb_bytes = TB_W'(in_vl) << in_vsew;
  assign illegal  = in_vill || (in_vsew > MaxVsew);

  always_comb begin
    tail_be = '0;
    for (int i = 0; i < BPB; i++) begin
      tail_be[i] = (rem_q > TB_W'(i));
    end
  end

  always_comb begin
    in_ready   = (state_q == StIdle);
    beat_valid = (state_q == StRun);
    beat_last  = beat_valid && (rem_q <= BpbW);
    beat_be    = '0;
    if (beat_valid) begin
      beat_be = beat_last ? tail_be : '1;
    end
    beat_idx = idx_q;
    done     = done_q;
    err      = err_q;
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          if (illegal) begin
            err_d = 1'b1;
          end else if (in_vl == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = StRun;
            rem_d   = tb_bytes;
            idx_d   = '0;
          end
        end
      end
      StRun: begin
        if (beat_ready) begin
          if (beat_last) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
            rem_d = rem_q - BpbW;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      rem_q   <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_vbeat_seq.sv
// Directed self-checking bench for vbeat_seq, with a second instance built without 64-bit SEW.
module tb_vbeat_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [11:0] in_vl = '0;
  logic [2:0]  in_vsew = '0;
  logic        in_vill = 1'b0;
  logic        beat_valid;
  logic        beat_ready = 1'b1;
  logic [10:0] beat_idx;
  logic [7:0]  beat_be;
  logic        beat_last;
  logic        done;
  logic        err;

  logic        in_valid2 = 1'b0;
  logic        in_ready2;
  logic        beat_valid2;
  logic [10:0] beat_idx2;
  logic [7:0]  beat_be2;
  logic        beat_last2;
  logic        done2;
  logic        err2;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  vbeat_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_vl(in_vl),
    .in_vsew(in_vsew), .in_vill(in_vill), .beat_valid(beat_valid), .beat_ready(beat_ready),
    .beat_idx(beat_idx), .beat_be(beat_be), .beat_last(beat_last), .done(done), .err(err)
  );

  vbeat_seq #(.ENABLE_64_BIT(1'b0)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2), .in_vl(in_vl),
    .in_vsew(in_vsew), .in_vill(in_vill), .beat_valid(beat_valid2), .beat_ready(beat_ready),
    .beat_idx(beat_idx2), .beat_be(beat_be2), .beat_last(beat_last2), .done(done2),
    .err(err2)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int vl, input int sew, input bit vill);
    in_vl    = 12'(vl);
    in_vsew  = 3'(sew);
    in_vill  = vill;
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
  endtask

  task automatic issue32(input int vl, input int sew);
    in_vl     = 12'(vl);
    in_vsew   = 3'(sew);
    in_vill   = 1'b0;
    in_valid2 = 1'b1;
    cyc();
    in_valid2 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc();
    cyc();
    tests++;
    if ({beat_valid, beat_idx, beat_be, beat_last, done, err} !== '0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset: valid=%b idx=%0d be=%h last=%b done=%b err=%b rdy=%b, want 0s rdy=1",
               beat_valid, beat_idx, beat_be, beat_last, done, err, in_ready);
    end
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_single_beat();
    issue(5, 0, 1'b0);
    tests++;
    if (beat_valid !== 1'b1 || beat_idx !== 11'd0 || beat_be !== 8'h1f || beat_last !== 1'b1 ||
        in_ready !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      fails++;
      $display("FAIL single_beat: valid=%b idx=%0d be=%h last=%b rdy=%b done=%b err=%b, want 1 0 1f 1 0 0 0",
               beat_valid, beat_idx, beat_be, beat_last, in_ready, done, err);
    end
    cyc();
    tests++;
    if (done !== 1'b1 || beat_valid !== 1'b0 || in_ready !== 1'b1 || err !== 1'b0) begin
      fails++;
      $display("FAIL single_done: done=%b valid=%b rdy=%b err=%b, want 1 0 1 0",
               done, beat_valid, in_ready, err);
    end
    cyc();
    tests++;
    if (done !== 1'b0) begin
      fails++;
      $display("FAIL single_done_pulse: done=%b, want 0", done);
    end
  endtask

  task automatic test_tail_mask();
    logic [7:0] exp_be [3];
    exp_be[0] = 8'hff;
    exp_be[1] = 8'hff;
    exp_be[2] = 8'h0f;
    issue(5, 2, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (beat_valid !== 1'b1 || beat_idx !== 11'(i) || beat_be !== exp_be[i] ||
          beat_last !== (i == 2) || done !== 1'b0) begin
        fails++;
        $display("FAIL tail_beat%0d: valid=%b idx=%0d be=%h last=%b done=%b, want 1 %0d %h %b 0",
                 i, beat_valid, beat_idx, beat_be, beat_last, done, i, exp_be[i], i == 2);
      end
      cyc();
    end
    tests++;
    if (done !== 1'b1 || beat_valid !== 1'b0) begin
      fails++;
      $display("FAIL tail_done: done=%b valid=%b, want 1 0", done, beat_valid);
    end
    cyc();
  endtask

  task automatic test_degenerate();
    issue(0, 0, 1'b0);
    tests++;
    if (done !== 1'b1 || err !== 1'b0 || beat_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL vl0: done=%b err=%b valid=%b rdy=%b, want 1 0 0 1",
               done, err, beat_valid, in_ready);
    end
    issue(5, 0, 1'b1);
    tests++;
    if (err !== 1'b1 || done !== 1'b0 || beat_valid !== 1'b0) begin
      fails++;
      $display("FAIL vill: err=%b done=%b valid=%b, want 1 0 0", err, done, beat_valid);
    end
    cyc();
    tests++;
    if (err !== 1'b0 || beat_valid !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL vill_after: err=%b valid=%b done=%b, want 0 0 0", err, beat_valid, done);
    end
    issue(5, 4, 1'b0);
    tests++;
    if (err !== 1'b1 || done !== 1'b0 || beat_valid !== 1'b0) begin
      fails++;
      $display("FAIL vsew4: err=%b done=%b valid=%b, want 1 0 0", err, done, beat_valid);
    end
    cyc();
  endtask

  task automatic test_backpressure();
    int delivered = 0;
    issue(3, 3, 1'b0);
    tests++;
    if (beat_valid !== 1'b1 || beat_idx !== 11'd0 || beat_be !== 8'hff || beat_last !== 1'b0) begin
      fails++;
      $display("FAIL bp_beat0: valid=%b idx=%0d be=%h last=%b, want 1 0 ff 0",
               beat_valid, beat_idx, beat_be, beat_last);
    end
    delivered++;
    cyc();
    beat_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (beat_valid !== 1'b1 || beat_idx !== 11'd1 || beat_be !== 8'hff || beat_last !== 1'b0) begin
        fails++;
        $display("FAIL bp_hold%0d: valid=%b idx=%0d be=%h last=%b, want 1 1 ff 0",
                 i, beat_valid, beat_idx, beat_be, beat_last);
      end
      cyc();
    end
    beat_ready = 1'b1;
    delivered++;
    cyc();
    tests++;
    if (beat_valid !== 1'b1 || beat_idx !== 11'd2 || beat_be !== 8'hff || beat_last !== 1'b1) begin
      fails++;
      $display("FAIL bp_beat2: valid=%b idx=%0d be=%h last=%b, want 1 2 ff 1",
               beat_valid, beat_idx, beat_be, beat_last);
    end
    delivered++;
    cyc();
    tests++;
    if (done !== 1'b1 || beat_valid !== 1'b0 || delivered != 3) begin
      fails++;
      $display("FAIL bp_done: done=%b valid=%b beats=%0d, want 1 0 3", done, beat_valid, delivered);
    end
    cyc();
  endtask

  task automatic test_max_group();
    int bad = 0;
    int dones = 0;
    issue(2048, 3, 1'b0);
    for (int i = 0; i < 2048; i++) begin
      if (beat_valid !== 1'b1 || beat_idx !== 11'(i) || beat_be !== 8'hff ||
          beat_last !== (i == 2047) || done !== 1'b0) begin
        if (bad == 0) begin
          $display("FAIL max_beat%0d: valid=%b idx=%0d be=%h last=%b, want 1 %0d ff %b",
                   i, beat_valid, beat_idx, beat_be, beat_last, i, i == 2047);
        end
        bad++;
      end
      cyc();
    end
    tests++;
    if (bad != 0) fails++;
    for (int i = 0; i < 3; i++) begin
      if (done === 1'b1) dones++;
      cyc();
    end
    tests++;
    if (dones != 1 || beat_valid !== 1'b0) begin
      fails++;
      $display("FAIL max_done: done pulses=%0d valid=%b, want 1 0", dones, beat_valid);
    end
    issue32(2048, 3);
    tests++;
    if (err2 !== 1'b1 || beat_valid2 !== 1'b0 || done2 !== 1'b0) begin
      fails++;
      $display("FAIL no64_err: err=%b valid=%b done=%b, want 1 0 0", err2, beat_valid2, done2);
    end
    cyc();
    issue32(1, 2);
    tests++;
    if (beat_valid2 !== 1'b1 || beat_be2 !== 8'h0f || beat_last2 !== 1'b1 || err2 !== 1'b0) begin
      fails++;
      $display("FAIL no64_sew2: valid=%b be=%h last=%b err=%b, want 1 0f 1 0",
               beat_valid2, beat_be2, beat_last2, err2);
    end
    cyc();
    tests++;
    if (done2 !== 1'b1) begin
      fails++;
      $display("FAIL no64_done: done=%b, want 1", done2);
    end
    cyc();
  endtask

  task automatic test_reset_mid_run();
    issue(3, 3, 1'b0);
    cyc();
    tests++;
    if (beat_idx !== 11'd1 || beat_valid !== 1'b1) begin
      fails++;
      $display("FAIL abort_setup: idx=%0d valid=%b, want 1 1", beat_idx, beat_valid);
    end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    tests++;
    if (beat_valid !== 1'b0 || in_ready !== 1'b1 || done !== 1'b0 || err !== 1'b0) begin
      fails++;
      $display("FAIL abort: valid=%b rdy=%b done=%b err=%b, want 0 1 0 0",
               beat_valid, in_ready, done, err);
    end
    cyc();
    tests++;
    if (done !== 1'b0 || beat_valid !== 1'b0) begin
      fails++;
      $display("FAIL abort_after: done=%b valid=%b, want 0 0", done, beat_valid);
    end
    issue(9, 0, 1'b0);
    tests++;
    if (beat_valid !== 1'b1 || beat_idx !== 11'd0 || beat_be !== 8'hff || beat_last !== 1'b0) begin
      fails++;
      $display("FAIL abort_next0: valid=%b idx=%0d be=%h last=%b, want 1 0 ff 0",
               beat_valid, beat_idx, beat_be, beat_last);
    end
    cyc();
    tests++;
    if (beat_idx !== 11'd1 || beat_be !== 8'h01 || beat_last !== 1'b1) begin
      fails++;
      $display("FAIL abort_next1: idx=%0d be=%h last=%b, want 1 01 1", beat_idx, beat_be, beat_last);
    end
    cyc();
    tests++;
    if (done !== 1'b1) begin
      fails++;
      $display("FAIL abort_next_done: done=%b, want 1", done);
    end
    cyc();
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_tail_mask();
    test_degenerate();
    test_backpressure();
    test_max_group();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
